mb_fetch_ctrl: RTL and testbench
================================

Name: mb_fetch_ctrl

Overview:
- Macroblock fetch sequencer that sits directly downstream of the 13-entry macroblock index counter (indices 0..12).
- Consumes the counter's current index and zero flag. Drives the counter's enable.
- Issues a burst of WORDS_PER_MB read requests per macroblock to the buffer memory over a valid/ready handshake, so that one frame (all 13 macroblocks) is walked per start command.

Parameters:
WORDS_PER_MB, 16, words fetched per macroblock (>=1)
ADDR_W, 8, read address width
BASE_ADDR, 0, address of word 0 of macroblock 0
MB_LAST, 12, highest macroblock index; must match the counter's wrap value

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  begin one frame fetch; sampled only in IDLE
mb_idx  input  4  current macroblock index from counter
mb_zero  input  1  counter zero flag (mb_idx==0)
rd_ready  input  1  memory accepts request this cycle
rd_valid  output  1  read request valid
rd_addr  output  ADDR_W  read word address
mb_adv  output  1  one-cycle enable to the macroblock counter
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst=0, async): state=IDLE, word_cnt=0. rd_valid, mb_adv, busy and done are all 0. rd_addr=BASE_ADDR. The counter receives the same system reset, so mb_idx=0 afterwards.
- States: IDLE, ISSUE, ADVANCE, CHECK, DONE. All outputs are registered or decoded from state only; there is no combinational path from rd_ready to rd_valid.
- IDLE: start=1 -> ISSUE, word_cnt=0. start is ignored in every other state.
- ISSUE: rd_valid=1.
  - rd_addr = BASE_ADDR + mb_idx*WORDS_PER_MB + word_cnt, truncated to ADDR_W.
  - rd_addr stays stable while rd_valid=1 and rd_ready=0.
  - On rd_valid&rd_ready: if word_cnt==WORDS_PER_MB-1, go to ADVANCE and set word_cnt=0; otherwise word_cnt+1.
  - rd_ready=0 simply stalls; there is no timeout.
- ADVANCE: mb_adv=1 for exactly one cycle, rd_valid=0. The counter updates at the closing edge. Next state is CHECK.
- CHECK: waits one cycle so the updated mb_zero is visible.
  - mb_zero=1 (counter wrapped from MB_LAST to 0) -> DONE.
  - Otherwise -> ISSUE.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Start with mb_idx != 0: the fetch runs from the current index through MB_LAST, then finishes. This is legal.
- Timing with rd_ready held 1: 18 cycles per macroblock (16 ISSUE, 1 ADVANCE, 1 CHECK). Counting from the edge that samples start:
  - first rd_valid is high in cycle 1;
  - done is high 234 cycles after start was sampled.
- mb_adv is never asserted outside ADVANCE. Exactly one mb_adv pulse per completed macroblock.
- Reset mid-operation: return immediately to IDLE with all outputs at reset values. Any partially issued burst is abandoned and is not resumed.
- The block never modifies mb_idx other than through mb_adv. mb_idx changing during ISSUE is a system error and is not checked.

Test Plan:
- Reset: rst=0 for 2 cycles with start=1 -> rd_valid=mb_adv=busy=done=0 and rd_addr=0. After release, start=1 for one cycle -> ISSUE, with rd_valid=1 and rd_addr=0 in the next cycle.
- Full frame, rd_ready=1: 208 accepted requests with addresses 0..207 in order and 13 mb_adv pulses. A scoreboard counter model wraps 12->0. done rises 234 cycles after start and lasts 1 cycle. busy falls the cycle after done.
- Backpressure: rd_ready toggles 1,0,0,1 repeatedly -> rd_addr stays constant across each stall, with no duplicate or skipped address. Final address is 207, still 13 mb_adv pulses.
- Mid-frame start: counter preloaded to mb_idx=10, then start -> addresses 160..207 and 3 mb_adv pulses. done fires after the 12->0 wrap.
- Reset mid-burst: rst=0 at word 5 of mb 3 -> outputs clear within the same cycle (async). A new start after release fetches from address 0.
- Start ignored: start pulses while busy, including in DONE -> no restart, no extra done. Exactly one frame is fetched.

Source files
------------

// File: rtl/mb_fetch_if.sv
// mb_fetch_if: valid/ready read-request bus between the fetch sequencer and buffer memory
interface mb_fetch_if #(parameter int ADDR_W = 8) ();
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  modport master (output rd_valid, rd_addr, input rd_ready);
  modport slave  (input rd_valid, rd_addr, output rd_ready);
endinterface

// File: rtl/mb_fetch_ctrl.sv
// mb_fetch_ctrl: walks one frame of macroblocks, issuing a WORDS_PER_MB read burst per block
module mb_fetch_ctrl #(
  parameter int WORDS_PER_MB = 16,
  parameter int ADDR_W       = 8,
  parameter int BASE_ADDR    = 0,
  parameter int MB_LAST      = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(MB_LAST+1)-1:0]     mb_idx,
  input  logic                             mb_zero,
  mb_fetch_if.master                       rd,
  output logic                             mb_adv,
  output logic                             busy,
  output logic                             done
);
  localparam int CW = WORDS_PER_MB > 1 ? $clog2(WORDS_PER_MB) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, ADVANCE, CHECK, DONE} state_t;
  state_t        state, nxt;
  logic [CW-1:0] word_cnt, word_nxt;
  logic          last_word;
  assign last_word = word_cnt == CW'(WORDS_PER_MB - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else begin
      state    <= nxt;
      word_cnt <= word_nxt;
    end
  always_comb begin
    nxt      = state;
    word_nxt = word_cnt;
    case (state)
      IDLE:    if (start) begin
                 nxt      = ISSUE;
                 word_nxt = '0;
               end
      ISSUE:   if (rd.rd_ready) begin
                 nxt      = last_word ? ADVANCE : ISSUE;
                 word_nxt = last_word ? '0 : word_cnt + 1'b1;
               end
      ADVANCE: nxt = CHECK;
      // counter updated at the end of ADVANCE, so mb_zero is valid here
      CHECK:   nxt = mb_zero ? DONE : ISSUE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign rd.rd_valid = state == ISSUE;
  assign rd.rd_addr  = state == ISSUE
                     ? ADDR_W'(BASE_ADDR) + ADDR_W'(mb_idx) * ADDR_W'(WORDS_PER_MB) + ADDR_W'(word_cnt)
                     : ADDR_W'(BASE_ADDR);
  assign mb_adv = state == ADVANCE;
  assign busy   = state != IDLE;
  assign done   = state == DONE;
endmodule

// File: tb/tb_mb_fetch_ctrl.sv
// tb_mb_fetch_ctrl: scoreboard bench with a 13-entry macroblock counter model driving the DUT
module tb_mb_fetch_ctrl;
  logic       clk = 0, rst = 0, start = 0;
  logic [3:0] mb_idx;
  logic       mb_zero, mb_adv, busy, done;
  logic [3:0] cnt, pre_val = 0;
  logic       pre_en = 0;
  int         rmode = 0;
  mb_fetch_if #(.ADDR_W(8)) rd ();
  mb_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mb_idx(mb_idx), .mb_zero(mb_zero),
    .rd(rd), .mb_adv(mb_adv), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (pre_en) cnt <= pre_val;
    else if (mb_adv) cnt <= cnt == 4'd12 ? 4'd0 : cnt + 4'd1;
  assign mb_idx  = cnt;
  assign mb_zero = cnt == 4'd0;
  logic [7:0] q[$];
  int checks = 0, errors = 0, adv_cnt = 0, done_cnt = 0;
  logic       stall = 0;
  logic [7:0] stall_addr = 0;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask
  initial begin
    int ph = 0;
    rd.rd_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      rd.rd_ready = rmode == 0 || ph % 4 == 0 || ph % 4 == 3;
      ph++;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      if (mb_adv) adv_cnt++;
      if (done) done_cnt++;
      if (stall && rd.rd_valid) chk("stall_hold", int'(rd.rd_addr), int'(stall_addr));
      if (rd.rd_valid && rd.rd_ready) begin
        if (q.size() == 0) chk("unexpected_req", int'(rd.rd_addr), -1);
        else chk("req_addr", int'(rd.rd_addr), int'(q.pop_front()));
      end
      stall      = rd.rd_valid && !rd.rd_ready;
      stall_addr = rd.rd_addr;
    end else stall = 0;
  end
  task automatic run_frame(input int first, input bit poke, input int exp_cyc);
    int cyc = 0;
    int a0 = adv_cnt, d0 = done_cnt;
    for (int i = first * 16; i < 208; i++) q.push_back(8'(i));
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("first_valid", int'(rd.rd_valid), 1);
    chk("first_addr", int'(rd.rd_addr), first * 16);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc % 37 == 5);
    end
    if (!done) chk("done_timeout", cyc, exp_cyc);
    else if (exp_cyc >= 0) chk("done_latency", cyc, exp_cyc);
    start = poke;
    @(negedge clk) start = 0;
    chk("done_width", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("stays_idle", int'(busy), 0);
    chk("adv_pulses", adv_cnt - a0, 13 - first);
    chk("done_pulses", done_cnt - d0, 1);
    chk("queue_drained", q.size(), 0);
  endtask
  initial begin
    int guard = 0;
    start = 1;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(rd.rd_valid), 0);
    chk("rst_adv", int'(mb_adv), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(rd.rd_addr), 0);
    start = 0;
    rst   = 1;
    @(negedge clk);
    run_frame(0, 0, 234);
    rmode = 1;
    run_frame(0, 0, -1);
    rmode = 0;
    @(negedge clk) begin pre_en = 1; pre_val = 4'd10; end
    @(negedge clk) pre_en = 0;
    run_frame(10, 0, 54);
    for (int i = 0; i < 208; i++) q.push_back(8'(i));
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    while (!(rd.rd_valid && rd.rd_addr == 8'd53) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_mb3_word5", int'(rd.rd_addr), 53);
    #2 rst = 0;
    #1;
    chk("async_valid", int'(rd.rd_valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_addr", int'(rd.rd_addr), 0);
    chk("async_adv", int'(mb_adv), 0);
    q.delete();
    @(negedge clk) rst = 1;
    @(negedge clk);
    run_frame(0, 1, 234);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
